route_demux: RTL and testbench

Two-way pipeline steering block for the RV32IM datapath: accepts one 32-bit result/operand stream with a valid/ready handshake and delivers each word to exactly one of two destinations. The two destinations are typically the single-cycle ALU path and the multi-cycle MUL/DIV unit. It is the distribution counterpart of the 2:1 select mux: SEL high routes to port 1, SEL low routes to port 2. Each destination has a one-entry registered slot, so backpressure from one destination never stalls a word bound for the other slot's consumer.

---
 rtl/route_demux_pkg.sv | 11 +
 rtl/route_slot.sv | 75 +++++++
 rtl/route_demux.sv | 78 +++++++
 tb/tb_route_demux.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/route_demux_pkg.sv
// Shared pipeline constants for the result-steering datapath.
package route_demux_pkg;

    // Native datapath width, the default for WIDTH.
    localparam int unsigned XLEN = 32;

    // Select encoding, matching the 2:1 mux convention.
    localparam logic SEL_PORT1 = 1'b1;
    localparam logic SEL_PORT2 = 1'b0;

endpackage

// File: rtl/route_slot.sv
// One-entry registered output slot with a wrapping delivery counter.
module route_slot
    import route_demux_pkg::*;
#(
    parameter int unsigned WIDTH   = XLEN,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic               i_load,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_valid,
    output logic [COUNT_W-1:0] o_count
);

    typedef enum logic {StEmpty, StFull} slot_state_e;

    slot_state_e        r_state;
    slot_state_e        w_state_next;
    logic [WIDTH-1:0]   r_data;
    logic [COUNT_W-1:0] r_count;
    logic               w_consume;

    assign w_consume = (r_state == StFull) && i_ready;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: flush dominates; a load keeps the slot full even when consumed.
    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = StEmpty;
        end else if (i_load) begin
            w_state_next = StFull;
        end else if (w_consume) begin
            w_state_next = StEmpty;
        end
    end

    // Output decode.
    always_comb begin
        o_valid = (r_state == StFull);
        o_data  = r_data;
        o_count = r_count;
    end

    // Data register: loads only on accept, otherwise holds its last word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data <= '0;
        end else if (i_load && !i_flush) begin
            r_data <= i_data;
        end
    end

    // Delivery counter: a handshake during flush is still a completed delivery.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (w_consume) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/route_demux.sv
// Steers one valid/ready word stream to one of two registered destination slots.
module route_demux
    import route_demux_pkg::*;
#(
    parameter int unsigned WIDTH   = XLEN,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               FLUSH,
    input  logic [WIDTH-1:0]   IN_DATA,
    input  logic               IN_SEL,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [WIDTH-1:0]   OUT1_DATA,
    output logic               OUT1_VALID,
    input  logic               OUT1_READY,
    output logic [WIDTH-1:0]   OUT2_DATA,
    output logic               OUT2_VALID,
    input  logic               OUT2_READY,
    output logic [COUNT_W-1:0] OUT1_COUNT,
    output logic [COUNT_W-1:0] OUT2_COUNT
);

    logic w_accept;
    logic w_load1;
    logic w_load2;

    // Ready depends only on the selected slot, so a stalled port never blocks the other.
    always_comb begin
        IN_READY = 1'b0;
        if (!FLUSH) begin
            if (IN_SEL == SEL_PORT1) begin
                IN_READY = !OUT1_VALID || OUT1_READY;
            end else begin
                IN_READY = !OUT2_VALID || OUT2_READY;
            end
        end
    end

    // Load-enable decode.
    always_comb begin
        w_accept = IN_VALID && IN_READY;
        w_load1  = w_accept && (IN_SEL == SEL_PORT1);
        w_load2  = w_accept && (IN_SEL == SEL_PORT2);
    end

    route_slot #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) u_slot1 (
        .i_clk   (CLK),
        .i_reset (RESET),
        .i_flush (FLUSH),
        .i_load  (w_load1),
        .i_data  (IN_DATA),
        .i_ready (OUT1_READY),
        .o_data  (OUT1_DATA),
        .o_valid (OUT1_VALID),
        .o_count (OUT1_COUNT)
    );

    route_slot #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W)
    ) u_slot2 (
        .i_clk   (CLK),
        .i_reset (RESET),
        .i_flush (FLUSH),
        .i_load  (w_load2),
        .i_data  (IN_DATA),
        .i_ready (OUT2_READY),
        .o_data  (OUT2_DATA),
        .o_valid (OUT2_VALID),
        .o_count (OUT2_COUNT)
    );

endmodule

// File: tb/tb_route_demux.sv
// Self-checking bench for route_demux: directed cases plus randomized traffic.
module tb_route_demux;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        FLUSH = 1'b0;
    logic [31:0] IN_DATA = '0;
    logic        IN_SEL = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] OUT1_DATA;
    logic        OUT1_VALID;
    logic        OUT1_READY = 1'b0;
    logic [31:0] OUT2_DATA;
    logic        OUT2_VALID;
    logic        OUT2_READY = 1'b0;
    logic [15:0] OUT1_COUNT;
    logic [15:0] OUT2_COUNT;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Reference model: per port, occupancy, held word and delivery count.
    bit          m_full [2] = '{0, 0};
    logic [31:0] m_data [2] = '{32'h0, 32'h0};
    logic [15:0] m_cnt  [2] = '{16'h0, 16'h0};

    route_demux u_dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .FLUSH      (FLUSH),
        .IN_DATA    (IN_DATA),
        .IN_SEL     (IN_SEL),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .OUT1_DATA  (OUT1_DATA),
        .OUT1_VALID (OUT1_VALID),
        .OUT1_READY (OUT1_READY),
        .OUT2_DATA  (OUT2_DATA),
        .OUT2_VALID (OUT2_VALID),
        .OUT2_READY (OUT2_READY),
        .OUT1_COUNT (OUT1_COUNT),
        .OUT2_COUNT (OUT2_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Port index 0 is OUT1 (SEL=1), index 1 is OUT2 (SEL=0).
    function automatic bit exp_ready();
        bit p2;
        p2 = (IN_SEL == 1'b0);
        if (FLUSH) return 1'b0;
        return !m_full[p2] || (p2 ? OUT2_READY : OUT1_READY);
    endfunction

    // Model advance at each rising edge.
    always @(posedge CLK) begin
        bit c0, c1, acc, p2;
        c0  = m_full[0] && OUT1_READY;
        c1  = m_full[1] && OUT2_READY;
        acc = IN_VALID && exp_ready();
        p2  = (IN_SEL == 1'b0);
        if (RESET) begin
            m_full <= '{0, 0};
            m_data <= '{32'h0, 32'h0};
            m_cnt  <= '{16'h0, 16'h0};
        end else begin
            m_cnt[0] <= m_cnt[0] + 16'(c0);
            m_cnt[1] <= m_cnt[1] + 16'(c1);
            if (FLUSH) begin
                m_full <= '{0, 0};
            end else begin
                if (acc && !p2) begin
                    m_full[0] <= 1'b1;
                    m_data[0] <= IN_DATA;
                end else if (c0) begin
                    m_full[0] <= 1'b0;
                end
                if (acc && p2) begin
                    m_full[1] <= 1'b1;
                    m_data[1] <= IN_DATA;
                end else if (c1) begin
                    m_full[1] <= 1'b0;
                end
            end
        end
    end

    // Every-cycle compare against the model, mid-cycle.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_in_ready", 32'(IN_READY), 32'(exp_ready()));
            chk("m_out1_valid", 32'(OUT1_VALID), 32'(m_full[0]));
            chk("m_out2_valid", 32'(OUT2_VALID), 32'(m_full[1]));
            chk("m_out1_count", 32'(OUT1_COUNT), 32'(m_cnt[0]));
            chk("m_out2_count", 32'(OUT2_COUNT), 32'(m_cnt[1]));
            if (m_full[0]) chk("m_out1_data", OUT1_DATA, m_data[0]);
            if (m_full[1]) chk("m_out2_data", OUT2_DATA, m_data[1]);
        end
    end

    // Drive one cycle of inputs just after the edge, then wait to mid-cycle.
    task automatic step(input logic v, input logic s, input logic [31:0] d, input logic r1,
                        input logic r2, input logic fl, input logic rs);
        @(posedge CLK);
        #1;
        IN_VALID   = v;
        IN_SEL     = s;
        IN_DATA    = d;
        OUT1_READY = r1;
        OUT2_READY = r2;
        FLUSH      = fl;
        RESET      = rs;
        @(negedge CLK);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_v1"}, 32'(OUT1_VALID), 32'h0);
        chk({tag, "_v2"}, 32'(OUT2_VALID), 32'h0);
        chk({tag, "_d1"}, OUT1_DATA, 32'h0);
        chk({tag, "_d2"}, OUT2_DATA, 32'h0);
        chk({tag, "_c1"}, 32'(OUT1_COUNT), 32'h0);
        chk({tag, "_c2"}, 32'(OUT2_COUNT), 32'h0);
        chk({tag, "_rdy"}, 32'(IN_READY), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          held;
        logic        h_sel;
        logic [31:0] h_data;
        logic        v, s;
        logic [31:0] d;

        // Reset values.
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk_reset_state("reset");

        // Single word to port 1.
        step(1, 1, 32'hAA, 1, 0, 0, 0);
        chk("aa_ready", 32'(IN_READY), 32'h1);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("aa_v1", 32'(OUT1_VALID), 32'h1);
        chk("aa_d1", OUT1_DATA, 32'hAA);
        chk("aa_v2", 32'(OUT2_VALID), 32'h0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("aa_c1", 32'(OUT1_COUNT), 32'h1);
        chk("aa_v1_drained", 32'(OUT1_VALID), 32'h0);

        // Port 1 stalled does not block port 2.
        step(1, 1, 32'h33, 0, 0, 0, 0);
        step(1, 1, 32'h44, 0, 0, 0, 0);
        chk("stall_ready1", 32'(IN_READY), 32'h0);
        chk("stall_d1", OUT1_DATA, 32'h33);
        step(1, 0, 32'h55, 0, 0, 0, 0);
        chk("other_ready2", 32'(IN_READY), 32'h1);
        chk("other_d1_hold", OUT1_DATA, 32'h33);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("other_v2", 32'(OUT2_VALID), 32'h1);
        chk("other_d2", OUT2_DATA, 32'h55);
        chk("other_v1", 32'(OUT1_VALID), 32'h1);

        // Flush with both full; port 2 consumes during flush.
        step(1, 0, 32'h66, 0, 1, 1, 0);
        chk("flush_ready", 32'(IN_READY), 32'h0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("flush_v1", 32'(OUT1_VALID), 32'h0);
        chk("flush_v2", 32'(OUT2_VALID), 32'h0);
        chk("flush_c1", 32'(OUT1_COUNT), 32'h1);
        chk("flush_c2", 32'(OUT2_COUNT), 32'h1);

        // Same-cycle consume and accept on port 1.
        step(1, 1, 32'h11, 0, 0, 0, 0);
        step(1, 1, 32'h22, 1, 0, 0, 0);
        chk("thru_ready", 32'(IN_READY), 32'h1);
        chk("thru_d1_old", OUT1_DATA, 32'h11);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("thru_v1", 32'(OUT1_VALID), 32'h1);
        chk("thru_d1_new", OUT1_DATA, 32'h22);
        chk("thru_c1", 32'(OUT1_COUNT), 32'h2);

        // Alternating stream, both readies high.
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, (i % 2) == 0, 32'h100 + 32'(i), 1, 1, 0, 0);
            chk("stream_ready", 32'(IN_READY), 32'h1);
        end
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("stream_c1", 32'(OUT1_COUNT), 32'h4);
        chk("stream_c2", 32'(OUT2_COUNT), 32'h4);

        // Randomized traffic with upstream hold rule.
        held = 1'b0;
        h_sel = 1'b0;
        h_data = '0;
        for (int i = 0; i < 3000; i++) begin
            if (held) begin
                v = 1'b1;
                s = h_sel;
                d = h_data;
            end else begin
                v = ($urandom_range(3) != 0);
                s = $urandom_range(1) == 1;
                d = $urandom;
            end
            step(v, s, d, $urandom_range(3) != 0, $urandom_range(3) != 0,
                 $urandom_range(15) == 0, $urandom_range(99) == 0);
            held   = IN_VALID && !exp_ready() && !RESET;
            h_sel  = IN_SEL;
            h_data = IN_DATA;
        end

        // Counter wrap on port 1.
        step(0, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 65535; n++) begin
            step(1, 1, 32'(n), 1, 0, 0, 0);
        end
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_ffff", 32'(OUT1_COUNT), 32'hFFFF);
        step(1, 1, 32'hDEAD, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_zero", 32'(OUT1_COUNT), 32'h0);

        // Reset while both slots are full drops them without counting.
        step(1, 1, 32'hA5, 0, 0, 0, 0);
        step(1, 0, 32'h5A, 0, 0, 0, 0);
        chk("prereset_v1", 32'(OUT1_VALID), 32'h1);
        step(0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk_reset_state("midreset");

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
